// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Provides the controller state encoding, word/line geometry and helpers
// that derive index/tag widths from the number of cache lines.
package dcache_pkg;

  localparam int OFF_W  = 2;    // word offset bits within a 4-word line
  localparam int WORD_W = 32;
  localparam int LINE_W = 128;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REFILL = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return WORD_W - OFF_W - $clog2(lines);
  endfunction

  // Selects word 'off' of a line; word k lives at bits [32k+31:32k].
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[{off, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid / tag / data storage for the direct-mapped cache.
// Ports:
//   rd_index                -> rd_valid, rd_tag, rd_line : combinational read
//   line_we/index/tag/data  : full-line fill, also sets tag and valid
//   word_we/index/offset/data : single-word update of a resident line
//   flush                   : clears every valid bit
// Only the valid bits are reset; tag and data contents are don't-care
// while their line is invalid.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IW    = 4,
  parameter int TW    = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     rd_index,
  output logic              rd_valid,
  output logic [TW-1:0]     rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              line_we,
  input  logic [IW-1:0]     line_index,
  input  logic [TW-1:0]     line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              word_we,
  input  logic [IW-1:0]     word_index,
  input  logic [OFF_W-1:0]  word_offset,
  input  logic [WORD_W-1:0] word_data,
  input  logic              flush
);

  logic [LINES-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[line_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_index]  <= line_tag;
      data_q[line_index] <= line_data;
    end else if (word_we) begin
      data_q[word_index][{word_offset, 5'b00000} +: WORD_W] <= word_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Ports:
//   cpu_*      : pipeline side. valid/ready: a request is taken on a rising
//                edge where cpu_req & cpu_ready & ~cpu_flush; cpu_req is a
//                level held until then. cpu_done pulses once per access.
//   mem_*      : DataMemory side (writeSig/address/inData, 128-bit mem_out).
//   hit_count/miss_count : saturating performance counters.
//   dbg_state  : current FSM state (state_t encoding).
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES   = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_flush,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              mem_writeSig,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_inData,
  input  logic [LINE_W-1:0] mem_out,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
  output logic [2:0]        dbg_state
);

  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;

  logic [IW-1:0]     index;
  logic [TW-1:0]     tag;
  logic [OFF_W-1:0]  offset;
  logic              rd_valid;
  logic [TW-1:0]     rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit;

  // Strobes decoded from the current state.
  logic accept, flush_all, start_mem, rd_from_cache, word_we, refill_done;
  logic write_end, hit_inc, miss_inc;

  assign offset = addr_q[OFF_W-1:0];
  assign index  = addr_q[OFF_W +: IW];
  assign tag    = addr_q[31 -: TW];
  assign hit    = rd_valid && (rd_tag == tag);

  dcache_array #(.LINES(LINES), .IW(IW), .TW(TW)) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_index    (index),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_line     (rd_line),
    .line_we     (refill_done),
    .line_index  (index),
    .line_tag    (tag),
    .line_data   (mem_out),
    .word_we     (word_we),
    .word_index  (index),
    .word_offset (offset),
    .word_data   (wdata_q),
    .flush       (flush_all)
  );

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    flush_all     = 1'b0;
    start_mem     = 1'b0;
    rd_from_cache = 1'b0;
    word_we       = 1'b0;
    refill_done   = 1'b0;
    write_end     = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Flush has priority over a simultaneous request.
        if (cpu_flush) begin
          flush_all = 1'b1;
        end else if (cpu_req) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          hit_inc = 1'b1;
          if (we_q) begin
            word_we   = 1'b1;
            start_mem = 1'b1;
            state_d   = S_WRITE;
          end else begin
            rd_from_cache = 1'b1;
            state_d       = S_DONE;
          end
        end else begin
          // Store misses go straight to memory without allocating.
          miss_inc  = 1'b1;
          start_mem = 1'b1;
          state_d   = we_q ? S_WRITE : S_REFILL;
        end
      end
      S_REFILL: begin
        if (cnt_q == '0) begin
          refill_done = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          write_end = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata    <= '0;
      mem_writeSig <= 1'b0;
      mem_address  <= '0;
      mem_inData   <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end

      // cnt counts down the memory cycles remaining after the current one.
      if (start_mem) begin
        cnt_q <= CNT_LAST;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      // Memory-side outputs are loaded on entry to REFILL/WRITE and then held.
      if (start_mem) begin
        mem_writeSig <= we_q;
        if (we_q) begin
          mem_address <= addr_q;
          mem_inData  <= wdata_q;
        end else begin
          mem_address <= {addr_q[31:OFF_W], {OFF_W{1'b0}}};
        end
      end else if (write_end) begin
        mem_writeSig <= 1'b0;
      end

      if (rd_from_cache) begin
        cpu_rdata <= line_word(rd_line, offset);
      end else if (refill_done) begin
        cpu_rdata <= line_word(mem_out, offset);
      end

      if (hit_inc && hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
      if (miss_inc && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

  assign cpu_ready = (state_q == S_IDLE);
  assign cpu_done  = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller. A word-addressed memory array
// stands in for DataMemory; a line-level model (valid/tag per index plus the
// memory contents, which a write-through cache always mirrors) predicts
// hit/miss, load data, latency and counter values.
module tb_dcache_controller;

  localparam int LINES   = 16;
  localparam int MEM_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we, cpu_flush;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_ready, cpu_done;
  logic [31:0]  cpu_rdata;
  logic         mem_writeSig;
  logic [31:0]  mem_address, mem_inData;
  logic [127:0] mem_out;
  logic [15:0]  hit_count, miss_count;
  logic [2:0]   dbg_state;

  dcache_controller #(.LINES(LINES), .MEM_LAT(MEM_LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_flush    (cpu_flush),
    .cpu_ready    (cpu_ready),
    .cpu_done     (cpu_done),
    .cpu_rdata    (cpu_rdata),
    .mem_writeSig (mem_writeSig),
    .mem_address  (mem_address),
    .mem_inData   (mem_inData),
    .mem_out      (mem_out),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / memory environment ----------------
  always #5 clk = ~clk;

  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (mem_writeSig) mem[mem_address[7:0]] <= mem_inData;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      mem_out[32*k +: 32] = mem[{mem_address[7:2], 2'(k)}];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic        ref_valid [LINES];
  logic [25:0] ref_tag   [LINES];
  int          ref_hits, ref_misses;
  logic [31:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_wsig", 32'(mem_writeSig), 32'd0);
    check("rst_maddr", mem_address, 32'd0);
    check("rst_mdata", mem_inData, 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_miss", 32'(miss_count), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!cpu_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(cpu_ready), 32'd1);
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic [3:0]  idx;
    logic [25:0] tg;
    logic        exp_hit;
    int          exp_lat, done_at, wr_cycles;
    idx     = addr[5:2];
    tg      = addr[31:6];
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
    exp_lat = (!we && exp_hit) ? 2 : 2 + MEM_LAT;
    if (!we) exp_q.push_back(mem[addr[7:0]]);

    wait_ready();
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    @(posedge clk);
    done_at   = 0;
    wr_cycles = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble the non-level inputs: they must be ignored now.
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (mem_writeSig) begin
        wr_cycles++;
        check("wr_addr", mem_address, addr);
        check("wr_data", mem_inData, wd);
      end
      if (!we && !exp_hit && k == 2) begin
        check("refill_addr", mem_address, {addr[31:2], 2'b00});
        check("refill_wsig", 32'(mem_writeSig), 32'd0);
      end
      if (cpu_done) begin
        done_at = k;
        break;
      end
    end
    check("latency", 32'(done_at), 32'(exp_lat));
    if (!we) check("rdata", cpu_rdata, exp_q.pop_front());
    check("wr_cycles", 32'(wr_cycles), we ? 32'(MEM_LAT) : 32'd0);

    if (exp_hit) begin
      if (ref_hits < 16'hFFFF) ref_hits++;
    end else begin
      if (ref_misses < 16'hFFFF) ref_misses++;
      if (!we) begin
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
      end
    end
    check("hit_count", 32'(hit_count), 32'(ref_hits));
    check("miss_count", 32'(miss_count), 32'(ref_misses));
  endtask

  // Flush with a simultaneous request: the request must not be taken.
  task automatic flush_with_req(input logic [31:0] addr);
    wait_ready();
    cpu_flush = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    check("flush_ready", 32'(cpu_ready), 32'd1);
    check("flush_done", 32'(cpu_done), 32'd0);
    cpu_flush = 1'b0;
    cpu_req   = 1'b0;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_flush = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 4; i < 8; i++) mem[i] = 32'(36 + i);   // words 4..7 = 40..43
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Load miss then hit on the same word.
    access(1'b0, 32'h5, 32'h0);
    check("first_load", cpu_rdata, 32'd41);
    access(1'b0, 32'h5, 32'h0);
    check("repeat_load", cpu_rdata, 32'd41);

    // Store miss (no allocate), then load misses and sees the new value.
    access(1'b1, 32'h14, 32'd15);
    access(1'b0, 32'h14, 32'h0);
    check("store_miss_load", cpu_rdata, 32'd15);

    // Store hit updates cache and memory; the following load is a hit.
    access(1'b0, 32'h5, 32'h0);
    access(1'b1, 32'h6, 32'd99);
    access(1'b0, 32'h6, 32'h0);
    check("store_hit_load", cpu_rdata, 32'd99);

    // Conflict on index 1.
    access(1'b0, 32'h45, 32'h0);
    access(1'b0, 32'h5, 32'h0);

    // Flush wins over a simultaneous request.
    flush_with_req(32'h5);
    access(1'b0, 32'h5, 32'h0);

    // Asynchronous reset in the middle of a refill.
    wait_ready();
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h25;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    check("mid_refill_addr", mem_address, 32'h24);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 32'h25, 32'h0);
    access(1'b0, 32'h5, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        flush_with_req($urandom_range(0, 255));
      end else begin
        access($urandom_range(0, 2) == 0, 32'($urandom_range(0, 255)), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
